ps2_rx: RTL and testbench
=========================

# ps2_rx

PS/2 device-to-host receiver: the host-side end of the keyboard link that SEND_TEST drives in simulation. It oversamples the asynchronous PS2CLK/DATA pair on the system clock and deserialises 11-bit frames (start, 8 data LSB-first, parity, stop). It folds the E0 (extended) and F0 (break) prefixes into a single per-key event, and hands scan codes to the calculator front-end as a one-cycle valid pulse.

## Interface
- FILTER, 3: PS2CLK must hold a new level for FILTER consecutive CLK cycles before the change is accepted (1..7).
- TIMEOUT, 1024: maximum CLK cycles allowed between accepted PS2CLK falling edges inside a frame.
- ODD_PARITY, 0: 0 means the parity bit equals the XOR of the 8 data bits (the link convention); 1 means the standard PS/2 inverted XOR.
- CLK  in  1  system clock; one clock domain.
- RST  in  1  reset, synchronous, active-high.
- PS2CLK  in  1  PS/2 clock from the device, asynchronous.
- DATA  in  1  PS/2 data from the device, asynchronous.
- KEY_CODE  out  8  final scan code of the event; holds its value between events.
- KEY_EXT  out  1  the event was preceded by E0; valid with KEY_VALID.
- KEY_BREAK  out  1  the event was preceded by F0 (key release); valid with KEY_VALID.
- KEY_VALID  out  1  one-cycle pulse per completed key event.
- FRAME_ERR  out  1  one-cycle pulse on parity, stop or timeout error.

## Operation
- Input conditioning: PS2CLK and DATA each pass through a 2-FF synchroniser.
- The synchronised PS2CLK then goes through a FILTER-cycle stability filter.
- FALL is a one-cycle pulse when the filtered clock goes from 1 to 0. All bits are sampled at FALL from the synchronised DATA.
- Frame FSM states: IDLE, DATA, PARITY, STOP.
- IDLE: on FALL with DATA=0, go to DATA and set bit counter to 0. On FALL with DATA=1 or X, stay in IDLE; this absorbs the leading low-high-low preamble.
- DATA: on FALL, shift DATA into bit[cnt]; after cnt=7, go to PARITY.
- PARITY: on FALL, compare DATA with ^shift (inverted when ODD_PARITY=1), latch a mismatch flag, go to STOP.
- STOP: on FALL, the frame is good only if DATA=1 and there was no parity mismatch.
  - Good frame: pass the byte to the prefix stage.
  - Bad frame: pulse FRAME_ERR and clear both prefix flags.
  - Either way, return to IDLE.
- Watchdog: a counter resets on every FALL and on entry to IDLE. If it reaches TIMEOUT in any state other than IDLE, pulse FRAME_ERR, go to IDLE and clear the prefix flags.
- Prefix stage, per good byte:
  - 8'hE0: set ext_flag; no output.
  - 8'hF0: set brk_flag; no output.
  - Any other byte: drive KEY_CODE = byte, KEY_EXT = ext_flag, KEY_BREAK = brk_flag, pulse KEY_VALID, then clear both flags.
- Repeated prefixes (E0 E0, F0 F0) are idempotent.

## Timing
- Reset values: KEY_CODE=8'h00, KEY_EXT=0, KEY_BREAK=0, KEY_VALID=0, FRAME_ERR=0. FSM is in IDLE, counters are 0, flags are clear.
- FALL is asserted exactly FILTER+3 cycles after the raw PS2CLK falling edge: 2 synchroniser cycles, FILTER filter cycles, 1 edge register.
- KEY_VALID and FRAME_ERR assert on the cycle after the FALL of the stop bit, so FILTER+4 cycles after the raw edge. They are never high together.
- KEY_CODE, KEY_EXT and KEY_BREAK update on the same edge as KEY_VALID rises.
- A FALL arriving on the same cycle as the watchdog expiry is treated as the timeout: error, then IDLE. That FALL is not treated as a start bit.
- RST asserted mid-frame aborts the frame with no FRAME_ERR. The first frame after reset is received normally.
- The minimum supported PS2CLK half-period is FILTER+2 CLK cycles; the link runs at 8.

## Structure
- Add PS2_PFX_EXT = 8'hE0 and PS2_PFX_BRK = 8'hF0 alongside the P_SCAN_* codes in scan_codes.v.
- The frame-state typedef lives in a shared package, ps2_pkg.
- Sub-module ps2_filter contains the synchroniser, stability filter and FALL generator. It is also reused by any future host-to-device transmitter.

## Test plan
- Send 'A' (8'h1C, parity bit 1) -> one KEY_VALID with KEY_CODE=8'h1C, EXT=0, BREAK=0, FILTER+4 cycles after the stop-bit fall.
- Send F0 then 1C -> no output after F0; after 1C, KEY_VALID with KEY_CODE=8'h1C, BREAK=1.
- Send E0 then 4A -> KEY_CODE=8'h4A, EXT=1.
- Send E0, F0, 4A -> KEY_CODE=8'h4A with EXT=1 and BREAK=1.
- Send 1C with parity bit 0 -> FRAME_ERR pulse, no KEY_VALID.
  - Follow with 5A (parity bit 0) -> KEY_VALID with KEY_CODE=8'h5A, flags clear.
- Stop PS2CLK after 4 data bits for more than 1024 cycles -> one FRAME_ERR pulse, then 8'h16 is received correctly.
- Assert RST after the start bit -> no output; the next frame 8'h5A is received correctly.
- Preamble low-high-low with DATA=X, followed by a full frame -> exactly one KEY_VALID.

Source files
------------

// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: frame FSM encoding, prefix scan codes and parity helper.
package ps2_pkg;

   typedef logic [1:0] frame_state_t;

   localparam frame_state_t ST_IDLE   = 2'd0;
   localparam frame_state_t ST_DATA   = 2'd1;
   localparam frame_state_t ST_PARITY = 2'd2;
   localparam frame_state_t ST_STOP   = 2'd3;

   localparam logic [7:0] PS2_PFX_EXT = 8'hE0;
   localparam logic [7:0] PS2_PFX_BRK = 8'hF0;

   // Expected parity bit for a data byte; odd=1 selects the standard inverted form.
   function automatic logic parity_of(input logic [7:0] b, input logic odd);
      return (^b) ^ odd;
   endfunction

endpackage

// File: rtl/ps2_filter.sv
// PS/2 line conditioning: 2-FF synchronisers, PS2CLK stability filter and falling-edge pulse.
// fall rises FILTER+3 cycles after a raw PS2CLK falling edge; data_sync is 2 cycles behind DATA.
module ps2_filter #(
   parameter int FILTER = 3
) (
   input  logic clk,
   input  logic rst,
   input  logic ps2clk,
   input  logic data,
   output logic fall,
   output logic data_sync
);

   logic [1:0] clk_sync;
   logic [1:0] dat_sync;
   logic       filt;
   logic       filt_d;
   logic [2:0] cnt;

   always_ff @(posedge clk) begin
      if (rst) begin
         clk_sync <= 2'b11;
         dat_sync <= 2'b11;
         filt     <= 1'b1;
         filt_d   <= 1'b1;
         cnt      <= 3'd0;
         fall     <= 1'b0;
      end else begin
         clk_sync <= {clk_sync[0], ps2clk};
         dat_sync <= {dat_sync[0], data};
         // Accept a new level only after FILTER consecutive samples disagree with the current one.
         if (clk_sync[1] == filt) begin
            cnt <= 3'd0;
         end else if (cnt == 3'(FILTER - 1)) begin
            filt <= clk_sync[1];
            cnt  <= 3'd0;
         end else begin
            cnt <= cnt + 3'd1;
         end
         filt_d <= filt;
         fall   <= filt_d & ~filt;
      end
   end

   assign data_sync = dat_sync[1];

endmodule

// File: rtl/ps2_rx.sv
// PS/2 device-to-host receiver: deserialises 11-bit frames and folds E0/F0 prefixes into key events.
// KEY_VALID / FRAME_ERR pulse FILTER+4 cycles after the raw stop-bit falling edge.
module ps2_rx
   import ps2_pkg::*;
#(
   parameter int FILTER     = 3,
   parameter int TIMEOUT    = 1024,
   parameter bit ODD_PARITY = 1'b0
) (
   input  logic       CLK,
   input  logic       RST,
   input  logic       PS2CLK,
   input  logic       DATA,
   output logic [7:0] KEY_CODE,
   output logic       KEY_EXT,
   output logic       KEY_BREAK,
   output logic       KEY_VALID,
   output logic       FRAME_ERR
);

   localparam int WDW = $clog2(TIMEOUT + 1);

   frame_state_t   state;
   logic [2:0]     bit_cnt;
   logic [7:0]     shift;
   logic           par_err;
   logic [WDW-1:0] wd_cnt;
   logic           ext_flag;
   logic           brk_flag;
   logic           fall;
   logic           data_s;
   logic           timeout;

   ps2_filter #(.FILTER(FILTER)) u_filter (
      .clk       (CLK),
      .rst       (RST),
      .ps2clk    (PS2CLK),
      .data      (DATA),
      .fall      (fall),
      .data_sync (data_s)
   );

   assign timeout = (state != ST_IDLE) && (wd_cnt == WDW'(TIMEOUT));

   always_ff @(posedge CLK) begin
      if (RST) begin
         state     <= ST_IDLE;
         bit_cnt   <= 3'd0;
         shift     <= 8'h00;
         par_err   <= 1'b0;
         wd_cnt    <= '0;
         ext_flag  <= 1'b0;
         brk_flag  <= 1'b0;
         KEY_CODE  <= 8'h00;
         KEY_EXT   <= 1'b0;
         KEY_BREAK <= 1'b0;
         KEY_VALID <= 1'b0;
         FRAME_ERR <= 1'b0;
      end else begin
         KEY_VALID <= 1'b0;
         FRAME_ERR <= 1'b0;
         wd_cnt    <= (state == ST_IDLE || fall) ? '0 : wd_cnt + WDW'(1);
         // Expiry wins over a coincident fall, which is then not taken as a start bit.
         if (timeout) begin
            FRAME_ERR <= 1'b1;
            ext_flag  <= 1'b0;
            brk_flag  <= 1'b0;
            state     <= ST_IDLE;
         end else if (fall) begin
            case (state)
               ST_IDLE: begin
                  if (data_s == 1'b0) begin
                     state   <= ST_DATA;
                     bit_cnt <= 3'd0;
                  end
               end
               ST_DATA: begin
                  shift[bit_cnt] <= data_s;
                  bit_cnt        <= bit_cnt + 3'd1;
                  if (bit_cnt == 3'd7) state <= ST_PARITY;
               end
               ST_PARITY: begin
                  par_err <= (data_s != parity_of(shift, ODD_PARITY));
                  state   <= ST_STOP;
               end
               default: begin
                  state <= ST_IDLE;
                  if (data_s && !par_err) begin
                     if (shift == PS2_PFX_EXT) begin
                        ext_flag <= 1'b1;
                     end else if (shift == PS2_PFX_BRK) begin
                        brk_flag <= 1'b1;
                     end else begin
                        KEY_CODE  <= shift;
                        KEY_EXT   <= ext_flag;
                        KEY_BREAK <= brk_flag;
                        KEY_VALID <= 1'b1;
                        ext_flag  <= 1'b0;
                        brk_flag  <= 1'b0;
                     end
                  end else begin
                     FRAME_ERR <= 1'b1;
                     ext_flag  <= 1'b0;
                     brk_flag  <= 1'b0;
                  end
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_ps2_rx.sv
// Bench for ps2_rx: table of key sequences, hand-built corner cases and a randomized run against a prefix model.
module tb_ps2_rx;

   localparam int FILTER = 3;
   localparam int H      = 8;

   logic       CLK = 1'b0;
   logic       RST = 1'b1;
   logic       PS2CLK = 1'b1;
   logic       DATA = 1'b1;
   logic [7:0] KEY_CODE;
   logic       KEY_EXT, KEY_BREAK, KEY_VALID, FRAME_ERR;

   ps2_rx #(.FILTER(FILTER), .TIMEOUT(1024), .ODD_PARITY(1'b0)) dut (
      .CLK(CLK), .RST(RST), .PS2CLK(PS2CLK), .DATA(DATA),
      .KEY_CODE(KEY_CODE), .KEY_EXT(KEY_EXT), .KEY_BREAK(KEY_BREAK),
      .KEY_VALID(KEY_VALID), .FRAME_ERR(FRAME_ERR)
   );

   always #5 CLK = ~CLK;

   typedef struct {
      bit         err;
      logic [7:0] code;
      bit         ext;
      bit         brk;
      bit         lat;
   } ev_t;

   typedef struct {
      int              n;
      logic [0:2][7:0] b;
      bit              bad_par;
      bit              bad_stop;
      bit              exp_err;
      logic [7:0]      exp_code;
      bit              exp_ext;
      bit              exp_brk;
   } vec_t;

   ev_t  exp_q[$];
   vec_t tbl[10];
   int   checks = 0;
   int   errors = 0;
   int   cyc = 0;
   int   stop_cyc = 0;
   bit   m_ext = 1'b0;
   bit   m_brk = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
      end
   endtask

   function automatic void push_ev(bit err, logic [7:0] code, bit ext, bit brk, bit lat);
      ev_t e;
      e.err = err; e.code = code; e.ext = ext; e.brk = brk; e.lat = lat;
      exp_q.push_back(e);
   endfunction

   // One clock: sample just after the edge and match any output event against the expected queue.
   task automatic tick();
      ev_t e;
      @(posedge CLK);
      #1;
      cyc++;
      if (KEY_VALID || FRAME_ERR) begin
         check("valid_err_exclusive", 32'(KEY_VALID & FRAME_ERR), 32'd0);
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_event: got valid=%0b err=%0b code=%0h, expected no event",
                     KEY_VALID, FRAME_ERR, KEY_CODE);
         end else begin
            e = exp_q.pop_front();
            check("event_is_error", 32'(FRAME_ERR), 32'(e.err));
            if (!e.err) begin
               check("key_code", 32'(KEY_CODE), 32'(e.code));
               check("key_ext", 32'(KEY_EXT), 32'(e.ext));
               check("key_break", 32'(KEY_BREAK), 32'(e.brk));
            end
            if (e.lat) check("latency_from_stop_fall", 32'(cyc - stop_cyc), 32'(FILTER + 4));
         end
      end
   endtask

   function automatic logic [10:0] mk_frame(logic [7:0] b, bit bad_par, bit bad_stop);
      return {~bad_stop, (^b) ^ bad_par, b, 1'b0};
   endfunction

   task automatic send_bits(input logic [10:0] frame, input int nbits);
      for (int i = 0; i < nbits; i++) begin
         DATA = frame[i];
         repeat (H) tick();
         PS2CLK = 1'b0;
         stop_cyc = cyc;
         repeat (H) tick();
         PS2CLK = 1'b1;
      end
      DATA = 1'b1;
   endtask

   task automatic send(input logic [7:0] b, input bit bad_par, input bit bad_stop);
      send_bits(mk_frame(b, bad_par, bad_stop), 11);
      repeat (20) tick();
   endtask

   // Reference: prefixes accumulate, a plain byte reports them, any bad frame discards them.
   function automatic void model_frame(logic [7:0] b, bit bad);
      if (bad) begin
         push_ev(1'b1, 8'h00, 1'b0, 1'b0, 1'b1);
         m_ext = 1'b0;
         m_brk = 1'b0;
      end else if (b == 8'hE0) begin
         m_ext = 1'b1;
      end else if (b == 8'hF0) begin
         m_brk = 1'b1;
      end else begin
         push_ev(1'b0, b, m_ext, m_brk, 1'b1);
         m_ext = 1'b0;
         m_brk = 1'b0;
      end
   endfunction

   initial begin
      logic [7:0] rb;
      bit         rbad;

      tbl[0] = '{1, {8'h1C, 8'h00, 8'h00}, 1'b0, 1'b0, 1'b0, 8'h1C, 1'b0, 1'b0};
      tbl[1] = '{2, {8'hF0, 8'h1C, 8'h00}, 1'b0, 1'b0, 1'b0, 8'h1C, 1'b0, 1'b1};
      tbl[2] = '{2, {8'hE0, 8'h4A, 8'h00}, 1'b0, 1'b0, 1'b0, 8'h4A, 1'b1, 1'b0};
      tbl[3] = '{3, {8'hE0, 8'hF0, 8'h4A}, 1'b0, 1'b0, 1'b0, 8'h4A, 1'b1, 1'b1};
      tbl[4] = '{1, {8'h1C, 8'h00, 8'h00}, 1'b1, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0};
      tbl[5] = '{1, {8'h5A, 8'h00, 8'h00}, 1'b0, 1'b0, 1'b0, 8'h5A, 1'b0, 1'b0};
      tbl[6] = '{3, {8'hF0, 8'hF0, 8'h1C}, 1'b0, 1'b0, 1'b0, 8'h1C, 1'b0, 1'b1};
      tbl[7] = '{3, {8'hE0, 8'hE0, 8'h75}, 1'b0, 1'b0, 1'b0, 8'h75, 1'b1, 1'b0};
      tbl[8] = '{2, {8'hE0, 8'h1C, 8'h00}, 1'b0, 1'b1, 1'b1, 8'h00, 1'b0, 1'b0};
      tbl[9] = '{1, {8'h1C, 8'h00, 8'h00}, 1'b0, 1'b0, 1'b0, 8'h1C, 1'b0, 1'b0};

      RST = 1'b1;
      repeat (3) tick();
      check("reset_key_code", 32'(KEY_CODE), 32'h00);
      check("reset_key_ext", 32'(KEY_EXT), 32'd0);
      check("reset_key_break", 32'(KEY_BREAK), 32'd0);
      check("reset_key_valid", 32'(KEY_VALID), 32'd0);
      check("reset_frame_err", 32'(FRAME_ERR), 32'd0);
      RST = 1'b0;
      repeat (10) tick();

      for (int i = 0; i < 10; i++) begin
         push_ev(tbl[i].exp_err, tbl[i].exp_code, tbl[i].exp_ext, tbl[i].exp_brk, 1'b1);
         for (int j = 0; j < tbl[i].n - 1; j++) send(tbl[i].b[j], 1'b0, 1'b0);
         send(tbl[i].b[tbl[i].n - 1], tbl[i].bad_par, tbl[i].bad_stop);
      end
      check("key_code_holds", 32'(KEY_CODE), 32'h1C);

      // Preamble: an idle-level fall with DATA high must not start a frame.
      DATA = 1'b1;
      repeat (H) tick();
      PS2CLK = 1'b0;
      repeat (H) tick();
      PS2CLK = 1'b1;
      push_ev(1'b0, 8'h1C, 1'b0, 1'b0, 1'b1);
      send(8'h1C, 1'b0, 1'b0);

      // Stalled frame: E0 then 4 data bits and silence; timeout also drops the E0.
      send(8'hE0, 1'b0, 1'b0);
      push_ev(1'b1, 8'h00, 1'b0, 1'b0, 1'b0);
      send_bits(mk_frame(8'h16, 1'b0, 1'b0), 5);
      repeat (1300) tick();
      push_ev(1'b0, 8'h16, 1'b0, 1'b0, 1'b1);
      send(8'h16, 1'b0, 1'b0);

      // Reset after a start bit: no output, pending F0 is forgotten.
      send(8'hF0, 1'b0, 1'b0);
      send_bits(mk_frame(8'h1C, 1'b0, 1'b0), 1);
      RST = 1'b1;
      repeat (3) tick();
      RST = 1'b0;
      repeat (10) tick();
      push_ev(1'b0, 8'h5A, 1'b0, 1'b0, 1'b1);
      send(8'h5A, 1'b0, 1'b0);

      m_ext = 1'b0;
      m_brk = 1'b0;
      for (int k = 0; k < 40; k++) begin
         case ($urandom_range(0, 3))
            0:       rb = 8'hE0;
            1:       rb = 8'hF0;
            default: begin
               rb = 8'($urandom);
               if (rb == 8'hE0 || rb == 8'hF0) rb = 8'h29;
            end
         endcase
         rbad = ($urandom_range(0, 7) == 0);
         model_frame(rb, rbad);
         send(rb, rbad, 1'b0);
      end

      repeat (50) tick();
      check("expected_events_drained", 32'(exp_q.size()), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
